// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-stage initiator: request opcodes,
// word-RAM control constants and the sequencing FSM state encoding.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    OP_LW = 2'b00,
    OP_SW = 2'b01,
    OP_LB = 2'b10,
    OP_SB = 2'b11
  } req_op_e;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b10;

  localparam logic [2:0] MEM_STAGE      = 3'b011;
  localparam logic [2:0] MEM_STAGE_IDLE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CAP   = 3'd2,
    ST_MERGE = 3'd3,
    ST_WR    = 3'd4,
    ST_RESP  = 3'd5
  } mac_state_e;

  // True for the two opcodes that return data from memory.
  function automatic logic is_load(input req_op_e op);
    return (op == OP_LW) || (op == OP_LB);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane helper on a little-endian 16-bit word: extracts one byte with
// sign extension for byte loads, and splices a new byte into the word for
// the read-modify-write of byte stores.
module mem_byte_lane (
  input  logic [15:0] word,
  input  logic        sel,
  input  logic [7:0]  byte_in,
  output logic [15:0] ext,
  output logic [15:0] merged
);

  logic [7:0] lane;

  // Pick the addressed byte, widen it with its sign bit, and build the word
  // with only the addressed lane replaced.
  always_comb begin
    lane   = sel ? word[15:8] : word[7:0];
    ext    = {{8{lane[7]}}, lane};
    merged = sel ? {byte_in, word[7:0]} : {word[15:8], byte_in};
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage initiator: takes one load/store at a time, drives the word
// RAM for one access cycle per RD/WR state, adds sign-extended byte loads and
// read-modify-write byte stores, and rejects misaligned or out-of-range
// requests without issuing any RAM cycle.
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  output logic [1:0]  mem_op,
  output logic [2:0]  mem_state,
  input  logic [15:0] mem_read_data
);

  mac_state_e  state;
  req_op_e     op_q;
  logic        byte_sel_q;
  logic [7:0]  byte_wdata_q;

  logic [31:0] word_idx;
  logic        misaligned;
  logic        out_of_range;
  logic [15:0] lane_ext;
  logic [15:0] lane_merged;

  // Request screening; only consulted at the accept edge in IDLE, so none of
  // this reaches an output without passing through a register.
  assign word_idx     = {17'd0, req_addr[15:1]};
  assign misaligned   = ((req_op == OP_LW) || (req_op == OP_SW)) && req_addr[0];
  assign out_of_range = (word_idx >= DEPTH_WORDS);

  assign req_ready = (state == ST_IDLE);

  mem_byte_lane u_lane (
    .word    (mem_read_data),
    .sel     (byte_sel_q),
    .byte_in (byte_wdata_q),
    .ext     (lane_ext),
    .merged  (lane_merged)
  );

  // Sequencing FSM; every RAM and response output is registered here and is
  // set on the edge that enters the state it belongs to. rsp_valid trails
  // entry to RESP by one cycle so the response is fully settled before it is
  // offered, and is only ever handshaken while it is already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      op_q           <= OP_LW;
      byte_sel_q     <= 1'b0;
      byte_wdata_q   <= 8'd0;
      mem_address    <= 16'd0;
      mem_write_data <= 16'd0;
      mem_op         <= MEM_OP_NONE;
      mem_state      <= MEM_STAGE_IDLE;
      rsp_valid      <= 1'b0;
      rsp_data       <= 16'd0;
      rsp_err        <= 1'b0;
    end else begin
      mem_op    <= MEM_OP_NONE;
      mem_state <= MEM_STAGE_IDLE;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q         <= req_op_e'(req_op);
            byte_sel_q   <= req_addr[0];
            byte_wdata_q <= req_wdata[7:0];
            if (misaligned || out_of_range) begin
              rsp_err  <= 1'b1;
              rsp_data <= 16'd0;
              state    <= ST_RESP;
            end else begin
              mem_address <= {1'b0, req_addr[15:1]};
              mem_state   <= MEM_STAGE;
              if (req_op == OP_SW) begin
                mem_op         <= MEM_OP_WRITE;
                mem_write_data <= req_wdata;
                state          <= ST_WR;
              end else begin
                mem_op <= MEM_OP_READ;
                state  <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          state <= is_load(op_q) ? ST_CAP : ST_MERGE;
        end
        ST_CAP: begin
          rsp_data <= (op_q == OP_LW) ? mem_read_data : lane_ext;
          rsp_err  <= 1'b0;
          state    <= ST_RESP;
        end
        ST_MERGE: begin
          mem_write_data <= lane_merged;
          mem_op         <= MEM_OP_WRITE;
          mem_state      <= MEM_STAGE;
          state          <= ST_WR;
        end
        ST_WR: begin
          rsp_data <= 16'd0;
          rsp_err  <= 1'b0;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 16'd0;
            rsp_err   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage initiator for the multi-cycle CPU. Accepts one load/store request at a time from the execute path over a valid/ready handshake, sequences the word RAM's `address`/`write_data`/`mem_op`/`state` inputs, captures `read_data`, and returns a registered response. Adds byte access on top of the word-only RAM: byte loads are sign-extended and byte stores use read-modify-write. Out-of-range and misaligned requests are rejected without touching the RAM.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 16-bit words; word indices at or above this are out of range.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  2  00 LW, 01 SW, 10 LB, 11 SB.
- `req_addr`  in  16  byte address; word index = `req_addr[15:1]`, byte select = `req_addr[0]`.
- `req_wdata`  in  16  store data; SB uses `[7:0]` only.
- `rsp_valid`  out  1  response held until accepted.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  16  load result; 0 for stores and errors.
- `rsp_err`  out  1  1 = misaligned or out of range.
- `mem_address`  out  16  to RAM `address` (word index, zero-extended).
- `mem_write_data`  out  16  to RAM `write_data`.
- `mem_op`  out  2  to RAM: 00 idle, 01 read, 10 write.
- `mem_state`  out  3  to RAM `state`: 3'b011 during an access cycle, else 3'b000.
- `mem_read_data`  in  16  from RAM `read_data`; valid the cycle after a read cycle.

## Operation
- States: IDLE, RD, CAP, MERGE, WR, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch op/addr/wdata, then check:
  - Word op with `req_addr[0]`=1 is misaligned.
  - Word index ≥ `DEPTH_WORDS` is out of range.
  - Either error -> RESP with `rsp_err`=1, `rsp_data`=0.
  - Otherwise LW/LB -> RD, SW -> WR, SB -> RD.
- RD: `mem_op`=01, `mem_state`=011. Next state is CAP for loads, MERGE for SB.
- CAP: capture `mem_read_data`. LW returns the full word. LB selects byte lane (`addr[0]`=0 -> `[7:0]`, 1 -> `[15:8]`) and sign-extends to 16 bits. Next state RESP.
- MERGE: replace the selected byte lane of `mem_read_data` with `req_wdata[7:0]`; keep the other lane. Next state WR.
- WR: `mem_op`=10, `mem_state`=011, `mem_write_data` = SW data or merged word. Next state RESP.
- RESP: `rsp_valid`=1 with data/err stable. Next state IDLE on `rsp_ready`; otherwise stay.
- All `mem_*` and `rsp_*` outputs come from registers or from a decode of the state register only. No combinational path from `req_*` or `rsp_ready`.
- Byte order is little-endian within the word.

## Timing
- Request handshake at edge T. Response `rsp_valid` rises after edge:
  - LW/LB: T+3.
  - SW: T+2.
  - SB: T+4.
  - Error: T+1.
- At most one outstanding request. Next `req_ready` is the cycle after the response handshake.
- Exactly one RAM access cycle per RD/WR state. `mem_op`=00 and `mem_state`=000 in every other state.
- `mem_address` is held stable from RD through WR of an SB.
- Reset (async, any state): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mem_op`=00, `mem_state`=000, `mem_address`=0, `mem_write_data`=0.
  - Reset during SB before WR leaves memory unchanged.
  - A write already sampled by the RAM stands.
- `rsp_ready` high while not in RESP is ignored.

## Structure
- Package `cpu_mem_pkg` holds:
  - request op codes (LW/SW/LB/SB);
  - RAM op constants MEM_OP_NONE=2'b00, MEM_OP_READ=2'b01, MEM_OP_WRITE=2'b10;
  - MEM_STAGE=3'b011 and MEM_STAGE_IDLE=3'b000;
  - the FSM state enum.
- Sub-module `mem_byte_lane` (combinational): byte extract with sign extension, and byte merge. Shared by CAP and MERGE.
- Bench instantiates the existing word RAM as the responder.

## Test plan
- SW addr 0x0010 data 0xBEEF, then LW 0x0010 -> `rsp_data`=0xBEEF, `rsp_err`=0; SW response at T+2, LW at T+3.
- Word 0x0020 holds 0x1234; SB addr 0x0021 data 0xAB -> word reads back 0xAB34. SB addr 0x0020 data 0xCD -> 0xABCD. Exactly one RAM read and one write per SB.
- Word 0x0030 holds 0x80FF: LB 0x0030 -> 0xFFFF; LB 0x0031 -> 0xFF80. Store 0x7F01: LB 0x0031 -> 0x007F.
- LW 0x0011 (misaligned) and SW 0x0800 (index 1024) -> `rsp_err`=1, `rsp_data`=0 at T+1; `mem_op` stays 00 throughout.
- Hold `rsp_ready`=0 for 5 cycles after LW -> `rsp_valid` and data stable, `req_ready`=0; a new `req_valid` is not accepted until the cycle after the handshake.
- Assert `rst_n`=0 in MERGE of SB to 0x0040 (holds 0x5555) -> outputs at reset values immediately; word still 0x5555; the next LW completes normally.
